serial_alu_unit: RTL and testbench
==================================

// Module: serial_alu_unit
// PURPOSE
//   Bit-serial ALU datapath; the consumer end of the Arithmetic_extender y_i interface.
//   Latches A, B and the M/S1/S0/Cin function code on a start request.
//   Each cycle it applies the arithmetic extender (y_i), the logic extender (x_i) and a
//   carry flip-flop to one bit pair, LSB first, and shifts the result into F.
//   Sits between the toy processor's register file and the result bus; busy/done handshake.
// PARAMETERS
//   WIDTH  8  operand/result width in bits (>=2)
// PORTS
//   clk       in   1      rising-edge clock
//   rst_n     in   1      reset: asynchronous and active-low
//   start     in   1      request; sampled only in IDLE
//   A         in   WIDTH  operand A
//   B         in   WIDTH  operand B
//   M         in   1      mode: 0 arithmetic, 1 logic
//   S1,S0     in   1,1    function select
//   Cin       in   1      carry-in (arithmetic only)
//   busy      out  1      high from cycle after accepted start until done
//   done      out  1      one-cycle pulse, F/Cout valid
//   F         out  WIDTH  result; held until next accepted start
//   Cout      out  1      final carry; 0 in logic mode
// BEHAVIOUR
//   Reset (async, any state): state=IDLE, busy=0, done=0, F=0, Cout=0, carry FF=0, flags=0.
//   FSM: IDLE --start--> SHIFT (latch A,B,M,S1,S0; carry FF<=M?0:Cin; bit count<=0).
//        SHIFT: process bit cnt; cnt==WIDTH-1 -> DONE. DONE: done=1, busy=0 -> IDLE.
//   Latency: start sampled at edge k -> busy high after k; done high in cycle k+WIDTH+1.
//   start while busy/DONE ignored, no queueing; latched operands unaffected by input changes.
//   Per bit i (a,b,c = current bits/carry):
//     y = M ? 0 : {00:0, 01:b, 10:~b, 11:1}[S1S0]
//     x = M ? {00:a&b, 01:a|b, 10:a^b, 11:~a}[S1S0] : a
//     f = x^y^c ; c_next = M ? 0 : (x&y)|(x&c)|(y&c)
//   Arithmetic: 00 A+Cin, 01 A+B+Cin, 10 A+~B+Cin, 11 A-1+Cin; modulo 2^WIDTH.
//   f shifted into F from MSB side; F updates only in SHIFT, so F shows partial
//   result while busy; F final at done. Cout = carry FF after bit WIDTH-1.
//   Carry into MSB captured for optional V flag.
//   Reset asserted mid-operation aborts with no done pulse; next start behaves as fresh.
// CONFIGURATION
//   SERIAL_ALU_FLAGS_EN defined: adds outputs Z (1, F==0) and V (1, signed overflow =
//     carry into MSB ^ Cout; 0 in logic mode), registered, valid with done, held
//     like F, reset 0.
//   Undefined: Z and V ports and their logic absent; all other behaviour identical.
// TESTING (WIDTH=8)
//   1 A=0x35,B=0x0A,M=0,S=01,Cin=0, start at edge 0 -> done cycle 9, F=0x3F, Cout=0.
//   2 A=0x10,B=0x01,M=0,S=10,Cin=1 -> F=0x0F, Cout=1; A=0x00,S=11,Cin=0 -> F=0xFF, Cout=0.
//   3 A=0xCC,B=0xAA,M=1: S=00->0x88, 01->0xEE, 10->0x66, 11->0x33; Cout=0, Cin=1 ignored.
//   4 Sweep all 16 {M,S1,S0,b} with A=0x5A,B=0x00/0xFF, Cin 0/1 -> F matches model.
//   5 start re-asserted while busy ignored (one done); rst_n low at bit 4 -> busy=0,
//     done=0, F=0 at once; later start gives correct result.
//   6 FLAGS_EN: A=0x7F,B=0x01,S=01 -> F=0x80,V=1,Z=0; A=0xFF,S=00,Cin=1 -> F=0,Z=1,Cout=1.

Source files
------------

// File: rtl/serial_alu_unit.sv
// ---------------------------------------------------------------------------
// serial_alu_unit
//
// Bit-serial ALU datapath. On an accepted start it latches operands A/B and
// the M/S1/S0/Cin function code, then processes one bit pair per clock, LSB
// first. Each bit goes through:
//   - an arithmetic extender producing y from b,
//   - a logic extender producing x from a and b,
//   - a full adder with a carry flip-flop.
// The sum bit is shifted into F from the MSB side.
//
// Optional feature (macro SERIAL_ALU_FLAGS_EN):
//   Defining it adds two registered outputs, valid with done and held like F:
//     Z  result is zero
//     V  signed overflow (0 in logic mode)
//   When the macro is undefined, those ports and their logic do not exist.
//
// Parameters
//   WIDTH  operand/result width in bits (>= 2)
//
// Ports
//   clk      rising-edge clock
//   rst_n    asynchronous active-low reset
//   start    operation request, sampled only while idle
//   A, B     operands
//   M        mode: 0 arithmetic, 1 logic
//   S1, S0   function select
//   Cin      carry-in (arithmetic mode only)
//   busy     high while bits are being shifted
//   done     one-cycle pulse; F and Cout are final
//   F        result (shows the partial result while busy)
//   Cout     final carry (0 in logic mode)
//   Z, V     zero / overflow flags (SERIAL_ALU_FLAGS_EN only)
// ---------------------------------------------------------------------------
module serial_alu_unit #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic             M,
  input  logic             S1,
  input  logic             S0,
  input  logic             Cin,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] F,
  output logic             Cout
`ifdef SERIAL_ALU_FLAGS_EN
  ,
  output logic             Z,
  output logic             V
`endif
);

  localparam int CNT_W = (WIDTH > 2) ? $clog2(WIDTH) : 1;
  localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(WIDTH - 1);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_DONE  = 2'd2
  } state_t;

  state_t           state_reg;
  state_t           state_next;

  logic [WIDTH-1:0] a_reg;
  logic [WIDTH-1:0] b_reg;
  logic             m_reg;
  logic [1:0]       s_reg;
  logic             c_reg;
  logic [CNT_W-1:0] cnt_reg;
  logic [WIDTH-1:0] f_reg;
  logic             cout_reg;

  logic             accept;
  logic             last_bit;
  logic             a_bit;
  logic             b_bit;
  logic             x_bit;
  logic             y_bit;
  logic             f_bit;
  logic             c_next;
  logic [WIDTH-1:0] f_shifted;

  assign accept    = (state_reg == ST_IDLE) && start;
  assign last_bit  = (cnt_reg == LAST_BIT);
  assign a_bit     = a_reg[0];
  assign b_bit     = b_reg[0];
  assign f_shifted = {f_bit, f_reg[WIDTH-1:1]};

  // -------------------------------------------------------------------------
  // FSM: state register
  // -------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg <= ST_IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  // -------------------------------------------------------------------------
  // FSM: next-state logic
  // -------------------------------------------------------------------------
  always_comb begin
    state_next = state_reg;
    case (state_reg)
      ST_IDLE:  if (start)    state_next = ST_SHIFT;
      ST_SHIFT: if (last_bit) state_next = ST_DONE;
      ST_DONE:                state_next = ST_IDLE;
      default:                state_next = ST_IDLE;
    endcase
  end

  // -------------------------------------------------------------------------
  // FSM: outputs
  // -------------------------------------------------------------------------
  always_comb begin
    busy = 1'b0;
    done = 1'b0;
    case (state_reg)
      ST_SHIFT: busy = 1'b1;
      ST_DONE:  done = 1'b1;
      default: ;
    endcase
  end

  // -------------------------------------------------------------------------
  // Per-bit extenders and full adder
  // -------------------------------------------------------------------------
  always_comb begin
    y_bit = 1'b0;
    x_bit = a_bit;
    if (!m_reg) begin
      // Arithmetic: B, ~B or all-ones gives A+Cin, A+B, A-B, A-1.
      case (s_reg)
        2'b00:   y_bit = 1'b0;
        2'b01:   y_bit = b_bit;
        2'b10:   y_bit = ~b_bit;
        default: y_bit = 1'b1;
      endcase
    end else begin
      case (s_reg)
        2'b00:   x_bit = a_bit & b_bit;
        2'b01:   x_bit = a_bit | b_bit;
        2'b10:   x_bit = a_bit ^ b_bit;
        default: x_bit = ~a_bit;
      endcase
    end
  end

  // In logic mode y is 0 and the carry FF starts at 0, so f reduces to x.
  assign f_bit  = x_bit ^ y_bit ^ c_reg;
  assign c_next = m_reg ? 1'b0 : ((x_bit & y_bit) | (x_bit & c_reg) | (y_bit & c_reg));

  // -------------------------------------------------------------------------
  // Datapath registers
  // -------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_reg    <= '0;
      b_reg    <= '0;
      m_reg    <= 1'b0;
      s_reg    <= 2'b00;
      c_reg    <= 1'b0;
      cnt_reg  <= '0;
      f_reg    <= '0;
      cout_reg <= 1'b0;
    end else if (accept) begin
      a_reg   <= A;
      b_reg   <= B;
      m_reg   <= M;
      s_reg   <= {S1, S0};
      c_reg   <= M ? 1'b0 : Cin;
      cnt_reg <= '0;
    end else if (state_reg == ST_SHIFT) begin
      // Operands shift right so bit 0 is always the current bit pair.
      a_reg   <= a_reg >> 1;
      b_reg   <= b_reg >> 1;
      c_reg   <= c_next;
      cnt_reg <= cnt_reg + CNT_W'(1);
      f_reg   <= f_shifted;
      if (last_bit) begin
        cout_reg <= c_next;
      end
    end
  end

  assign F    = f_reg;
  assign Cout = cout_reg;

`ifdef SERIAL_ALU_FLAGS_EN
  logic z_reg;
  logic v_reg;

  // During the last bit c_reg holds the carry into the MSB and c_next the
  // carry out; their XOR is the signed overflow. Both are 0 in logic mode.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      z_reg <= 1'b0;
      v_reg <= 1'b0;
    end else if ((state_reg == ST_SHIFT) && last_bit) begin
      z_reg <= (f_shifted == '0);
      v_reg <= c_reg ^ c_next;
    end
  end

  assign Z = z_reg;
  assign V = v_reg;
`endif

endmodule

// File: tb/tb_serial_alu_unit.sv
// Testbench for serial_alu_unit (WIDTH=8). A driver issues operations and
// pushes hand-computed expected results into a scoreboard queue; a monitor
// pops and compares whenever done is presented.
module tb_serial_alu_unit;

  localparam int WIDTH = 8;

  logic             clk = 1'b0;
  logic             rst_n = 1'b1;
  logic             start = 1'b0;
  logic [WIDTH-1:0] A = '0;
  logic [WIDTH-1:0] B = '0;
  logic             M = 1'b0;
  logic             S1 = 1'b0;
  logic             S0 = 1'b0;
  logic             Cin = 1'b0;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] F;
  logic             Cout;
`ifdef SERIAL_ALU_FLAGS_EN
  logic             Z;
  logic             V;
`endif

  int errors = 0;
  int checks = 0;

  typedef struct {
    logic [7:0] f;
    logic       cout;
    logic       z;
    logic       v;
    string      name;
  } exp_t;

  exp_t sb[$];

  serial_alu_unit #(.WIDTH(WIDTH)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .start (start),
    .A     (A),
    .B     (B),
    .M     (M),
    .S1    (S1),
    .S0    (S0),
    .Cin   (Cin),
    .busy  (busy),
    .done  (done),
    .F     (F),
    .Cout  (Cout)
`ifdef SERIAL_ALU_FLAGS_EN
    ,
    .Z     (Z),
    .V     (V)
`endif
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: actual=0x%0h required=0x%0h", name, act, req);
    end
  endtask

  // Monitor: compares every done pulse against the oldest expected entry.
  always @(negedge clk) begin
    if (rst_n && done) begin
      if (sb.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_done: actual=done pulse required=no pulse (F=0x%0h)", F);
      end else begin
        exp_t e;
        e = sb.pop_front();
        check({e.name, "_F"}, 32'(F), 32'(e.f));
        check({e.name, "_Cout"}, 32'(Cout), 32'(e.cout));
`ifdef SERIAL_ALU_FLAGS_EN
        check({e.name, "_Z"}, 32'(Z), 32'(e.z));
        check({e.name, "_V"}, 32'(V), 32'(e.v));
`endif
        $display("op %s: F=0x%02h Cout=%0b", e.name, F, Cout);
      end
    end
  end

  // Drive one start, scramble the inputs while busy, wait (bounded) for done.
  task automatic run_op(input logic [7:0] a, input logic [7:0] b, input logic m,
                        input logic [1:0] s, input logic cin, input logic [7:0] ef,
                        input logic ecout, input logic ez, input logic ev,
                        input string name);
    exp_t e;
    int   n;
    @(negedge clk);
    A = a; B = b; M = m; {S1, S0} = s; Cin = cin;
    start = 1'b1;
    e.f = ef; e.cout = ecout; e.z = ez; e.v = ev; e.name = name;
    sb.push_back(e);
    @(negedge clk);
    start = 1'b0;
    A = ~a; B = ~b; M = ~m; {S1, S0} = ~s; Cin = ~cin;
    check({name, "_busy"}, 32'(busy), 32'd1);
    n = 1;
    while (!done && n < WIDTH + 6) begin
      @(negedge clk);
      n++;
    end
    check({name, "_latency"}, 32'(n), 32'(WIDTH + 1));
  endtask

  typedef struct {
    logic       m;
    logic [1:0] s;
    logic [7:0] b;
    logic       cin;
    logic [7:0] f;
    logic       cout;
  } vec_t;

  // A = 0x5A for every row; hand-computed results.
  vec_t sweep[16] = '{
    '{1'b0, 2'b00, 8'h00, 1'b0, 8'h5A, 1'b0},
    '{1'b0, 2'b00, 8'hFF, 1'b1, 8'h5B, 1'b0},
    '{1'b0, 2'b01, 8'h00, 1'b1, 8'h5B, 1'b0},
    '{1'b0, 2'b01, 8'hFF, 1'b0, 8'h59, 1'b1},
    '{1'b0, 2'b10, 8'h00, 1'b0, 8'h59, 1'b1},
    '{1'b0, 2'b10, 8'hFF, 1'b1, 8'h5B, 1'b0},
    '{1'b0, 2'b11, 8'h00, 1'b1, 8'h5A, 1'b1},
    '{1'b0, 2'b11, 8'hFF, 1'b0, 8'h59, 1'b1},
    '{1'b1, 2'b00, 8'h00, 1'b1, 8'h00, 1'b0},
    '{1'b1, 2'b00, 8'hFF, 1'b1, 8'h5A, 1'b0},
    '{1'b1, 2'b01, 8'h00, 1'b1, 8'h5A, 1'b0},
    '{1'b1, 2'b01, 8'hFF, 1'b1, 8'hFF, 1'b0},
    '{1'b1, 2'b10, 8'h00, 1'b1, 8'h5A, 1'b0},
    '{1'b1, 2'b10, 8'hFF, 1'b1, 8'hA5, 1'b0},
    '{1'b1, 2'b11, 8'h00, 1'b1, 8'hA5, 1'b0},
    '{1'b1, 2'b11, 8'hFF, 1'b1, 8'hA5, 1'b0}
  };

  initial begin
    int n;
    #2 rst_n = 1'b0;
    #1;
    check("reset_busy", 32'(busy), 32'd0);
    check("reset_done", 32'(done), 32'd0);
    check("reset_F", 32'(F), 32'd0);
    check("reset_Cout", 32'(Cout), 32'd0);
`ifdef SERIAL_ALU_FLAGS_EN
    check("reset_Z", 32'(Z), 32'd0);
    check("reset_V", 32'(V), 32'd0);
`endif
    repeat (3) @(negedge clk);
    rst_n = 1'b1;

    // Basic arithmetic
    run_op(8'h35, 8'h0A, 1'b0, 2'b01, 1'b0, 8'h3F, 1'b0, 1'b0, 1'b0, "add");
    run_op(8'h10, 8'h01, 1'b0, 2'b10, 1'b1, 8'h0F, 1'b1, 1'b0, 1'b0, "sub");
    run_op(8'h00, 8'h01, 1'b0, 2'b11, 1'b0, 8'hFF, 1'b0, 1'b0, 1'b0, "dec");

    // Logic ops, Cin=1 must be ignored
    run_op(8'hCC, 8'hAA, 1'b1, 2'b00, 1'b1, 8'h88, 1'b0, 1'b0, 1'b0, "and");
    run_op(8'hCC, 8'hAA, 1'b1, 2'b01, 1'b1, 8'hEE, 1'b0, 1'b0, 1'b0, "or");
    run_op(8'hCC, 8'hAA, 1'b1, 2'b10, 1'b1, 8'h66, 1'b0, 1'b0, 1'b0, "xor");
    run_op(8'hCC, 8'hAA, 1'b1, 2'b11, 1'b1, 8'h33, 1'b0, 1'b0, 1'b0, "not");

    // Sweep of all {M,S1,S0,b}; V is 0 everywhere (no signed overflow here)
    for (int i = 0; i < 16; i++) begin
      run_op(8'h5A, sweep[i].b, sweep[i].m, sweep[i].s, sweep[i].cin, sweep[i].f,
             sweep[i].cout, 1'b0, 1'b0, $sformatf("sweep%0d", i));
    end

    // Flags corner cases
    run_op(8'h7F, 8'h01, 1'b0, 2'b01, 1'b0, 8'h80, 1'b0, 1'b0, 1'b1, "ovf");
    run_op(8'hFF, 8'h00, 1'b0, 2'b00, 1'b1, 8'h00, 1'b1, 1'b1, 1'b0, "zero");

    // start while busy and during DONE must be ignored
    @(negedge clk);
    A = 8'h21; B = 8'h12; M = 1'b0; {S1, S0} = 2'b01; Cin = 1'b0;
    start = 1'b1;
    sb.push_back('{8'h33, 1'b0, 1'b0, 1'b0, "nobusystart"});
    @(negedge clk);
    start = 1'b0;
    repeat (2) @(negedge clk);
    A = 8'hFF; B = 8'hFF; start = 1'b1;
    n = 0;
    while (!done && n < WIDTH + 6) begin
      @(negedge clk);
      n++;
    end
    check("nobusystart_seen", 32'(done), 32'd1);
    @(negedge clk);
    start = 1'b0;
    check("nobusystart_idle", 32'(busy), 32'd0);
    repeat (12) @(negedge clk);
    check("nobusystart_still_idle", 32'(busy), 32'd0);

    // Reset in the middle of an operation
    @(negedge clk);
    A = 8'h5A; B = 8'h33; M = 1'b0; {S1, S0} = 2'b01; Cin = 1'b0;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (4) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    check("abort_busy", 32'(busy), 32'd0);
    check("abort_done", 32'(done), 32'd0);
    check("abort_F", 32'(F), 32'd0);
    check("abort_Cout", 32'(Cout), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (12) @(negedge clk);
    check("abort_no_done", 32'(busy), 32'd0);
    run_op(8'h35, 8'h0A, 1'b0, 2'b01, 1'b0, 8'h3F, 1'b0, 1'b0, 1'b0, "fresh");

    repeat (3) @(negedge clk);
    check("scoreboard_drained", 32'(sb.size()), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: actual=timeout required=finish");
    $fatal(1, "watchdog expired");
  end

endmodule
